// File: rtl/cpu_icache_pkg.sv
// Shared CPU definitions for the instruction cache: FSM state type and default geometry.
package cpu_icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        REFILL,
        RESPOND
    } icache_state_t;

    localparam int ICACHE_ADDR_WIDTH = 32;
    localparam int ICACHE_LINES      = 64;
    localparam int ICACHE_WORDS      = 4;

endpackage

// File: rtl/cpu_icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled with modports.
interface cpu_icache_if #(
    parameter int ADDR_WIDTH = 32
);
    // Handshakes: a request or refill-request transfers on a cycle where valid && ready are both
    // high at the rising edge; valid holds its payload stable until then. resp_valid and
    // mem_resp_valid are single-cycle pulses with no ready (the receiver must take them).
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  resp_valid;
    logic [31:0]           resp_word;
    logic                  flush;
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [31:0]           mem_resp_data;

    modport master (
        output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_word, mem_req_valid, mem_req_addr
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_word, mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/cpu_icache_array.sv
// Tag/valid storage with combinational lookup, plus a synchronous-read data RAM (1R/1W).
module cpu_icache_array #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_BITS       = 26,
    localparam int IDX_BITS      = $clog2(LINES),
    localparam int WORD_BITS     = $clog2(WORDS_PER_LINE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [IDX_BITS-1:0]  lookup_idx,
    output logic [TAG_BITS-1:0]  lookup_tag,
    output logic                 lookup_valid,
    input  logic                 rd_en,
    input  logic [WORD_BITS-1:0] rd_off,
    output logic [31:0]          rd_data,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [WORD_BITS-1:0] wr_off,
    input  logic [31:0]          wr_data,
    input  logic                 tag_we,
    input  logic [TAG_BITS-1:0]  tag_data
);

    logic [31:0]         data_mem [LINES*WORDS_PER_LINE];
    logic [TAG_BITS-1:0] tags     [LINES];
    logic [LINES-1:0]    valid;

    assign lookup_tag   = tags[lookup_idx];
    assign lookup_valid = valid[lookup_idx];

    always_ff @(posedge clock) begin
        if (wr_en) data_mem[{wr_idx, wr_off}] <= wr_data;
        if (rd_en) rd_data <= data_mem[{lookup_idx, rd_off}];
        if (tag_we) tags[wr_idx] <= tag_data;
    end

    // Flush beats a same-cycle line install so a flushed refill never becomes visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/cpu_icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, burst line refill on miss, flush-all.
module cpu_icache
    import cpu_icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = ICACHE_ADDR_WIDTH,
    parameter int LINES          = ICACHE_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS
) (
    input  logic          clock,
    input  logic          reset,
    cpu_icache_if.slave   bus,
    output icache_state_t state
);

    localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFF_BITS  = WORD_BITS + 2;
    localparam int IDX_BITS  = $clog2(LINES);
    localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - OFF_BITS;
    localparam int LINE_BITS = ADDR_WIDTH - OFF_BITS;
    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(WORDS_PER_LINE - 1);

    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic [WORD_BITS-1:0] req_off;
    logic [TAG_BITS-1:0]  lookup_tag;
    logic                 lookup_valid;
    logic                 accept;
    logic                 hit;
    logic [31:0]          rd_data;

    logic [LINE_BITS-1:0] miss_line;
    logic [WORD_BITS-1:0] miss_off;
    logic [WORD_BITS-1:0] beat;
    logic                 flush_seen;
    logic                 hit_resp;
    logic                 resp_valid_r;
    logic [31:0]          resp_reg;
    logic                 mem_req_valid_r;
    logic [ADDR_WIDTH-1:0] mem_req_addr_r;
    logic                 wr_en;
    logic                 tag_we;

    assign req_idx = bus.req_addr[OFF_BITS +: IDX_BITS];
    assign req_tag = bus.req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_off = bus.req_addr[2 +: WORD_BITS];

    assign bus.req_ready = (state == IDLE) && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign hit           = lookup_valid && (lookup_tag == req_tag);

    assign wr_en  = (state == REFILL) && bus.mem_resp_valid;
    // A flush seen anywhere during this miss keeps the refilled line invalid.
    assign tag_we = wr_en && (beat == LAST_BEAT) && !flush_seen;

    // Hit data comes straight from the RAM read register; miss data from the captured beat.
    assign bus.resp_valid    = resp_valid_r;
    assign bus.resp_word     = hit_resp ? rd_data : resp_reg;
    assign bus.mem_req_valid = mem_req_valid_r;
    assign bus.mem_req_addr  = mem_req_addr_r;

    cpu_icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_BITS       (TAG_BITS)
    ) u_array (
        .clock        (clock),
        .reset        (reset),
        .flush        (bus.flush),
        .lookup_idx   (req_idx),
        .lookup_tag   (lookup_tag),
        .lookup_valid (lookup_valid),
        .rd_en        (accept),
        .rd_off       (req_off),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_idx       (miss_line[IDX_BITS-1:0]),
        .wr_off       (beat),
        .wr_data      (bus.mem_resp_data),
        .tag_we       (tag_we),
        .tag_data     (miss_line[IDX_BITS +: TAG_BITS])
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            beat            <= '0;
            miss_line       <= '0;
            miss_off        <= '0;
            flush_seen      <= 1'b0;
            hit_resp        <= 1'b0;
            resp_valid_r    <= 1'b0;
            resp_reg        <= '0;
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= '0;
        end else begin
            hit_resp     <= 1'b0;
            resp_valid_r <= 1'b0;
            if (bus.flush && state != IDLE) flush_seen <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            hit_resp     <= 1'b1;
                            resp_valid_r <= 1'b1;
                        end else begin
                            miss_line       <= bus.req_addr[ADDR_WIDTH-1:OFF_BITS];
                            miss_off        <= req_off;
                            flush_seen      <= 1'b0;
                            mem_req_valid_r <= 1'b1;
                            mem_req_addr_r  <= {bus.req_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                            state           <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        beat            <= '0;
                        state           <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_resp_valid) begin
                        if (beat == miss_off) resp_reg <= bus.mem_resp_data;
                        if (beat == LAST_BEAT) begin
                            resp_valid_r <= 1'b1;
                            state        <= RESPOND;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
